// File: rtl/mycpu_regfile_bypass_if.sv
// Register-file port bundle: one byte-enabled write port, two read ports, and
// the clear request/busy pair. Master = pipeline side, slave = register file.
interface mycpu_regfile_bypass_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH/8-1:0] wen;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ADDR_WIDTH-1:0]   raddr1;
    logic [ADDR_WIDTH-1:0]   raddr2;
    logic [DATA_WIDTH-1:0]   rdata1;
    logic [DATA_WIDTH-1:0]   rdata2;
    logic                    clr;
    logic                    busy;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2, clr,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2, clr,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/mycpu_regfile_bypass.sv
// myCPU general-purpose register file: byte-merge writes, two combinational
// read ports with optional write bypass, zero register and a clear sequencer.
module mycpu_regfile_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mycpu_regfile_bypass_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_rf [DEPTH];

    logic                    w_busy;
    logic                    w_wr_acc;
    logic [ADDR_WIDTH-1:0]   w_we_addr;
    logic [DATA_WIDTH-1:0]   w_we_data;
    logic [LANES-1:0]        w_we_lane;

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_wr_acc = !w_busy && (|bus.wen) &&
                      !((ZERO_REG != 0) && (bus.waddr == '0));
    assign bus.busy = w_busy;

    // Sequencer state; storage itself has no reset, it is zeroed by the sequencer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_next = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The sequencer owns the single write port while clearing.
    always_comb begin
        w_we_addr = bus.waddr;
        w_we_data = bus.wdata;
        w_we_lane = w_wr_acc ? bus.wen : '0;
        if (w_busy) begin
            w_we_addr = r_cnt;
            w_we_data = '0;
            w_we_lane = '1;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (w_we_lane[l]) begin
                r_rf[w_we_addr][8*l +: 8] <= w_we_data[8*l +: 8];
            end
        end
    end

    logic [ADDR_WIDTH-1:0] w_raddr [2];
    assign w_raddr[0] = bus.raddr1;
    assign w_raddr[1] = bus.raddr2;

    // Each read port resolves zero-register, bypass and busy on its own.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] w_rd;
            always_comb begin
                w_rd = r_rf[w_raddr[gi]];
                if ((BYPASS != 0) && w_wr_acc && (bus.waddr == w_raddr[gi])) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (bus.wen[l]) begin
                            w_rd[8*l +: 8] = bus.wdata[8*l +: 8];
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
                    w_rd = '0;
                end
                if (w_busy) begin
                    w_rd = '0;
                end
            end
        end
    endgenerate

    assign bus.rdata1 = g_rd[0].w_rd;
    assign bus.rdata2 = g_rd[1].w_rd;
endmodule

// File: tb/tb_mycpu_regfile_bypass.sv
// Directed bench for mycpu_regfile_bypass: a BYPASS=1 and a BYPASS=0 instance
// share the same stimulus so forwarding and non-forwarding reads can be compared.
module tb_mycpu_regfile_bypass;
    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_fail;

    mycpu_regfile_bypass_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    mycpu_regfile_bypass_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();

    assign bus_nb.wen    = bus.wen;
    assign bus_nb.waddr  = bus.waddr;
    assign bus_nb.wdata  = bus.wdata;
    assign bus_nb.raddr1 = bus.raddr1;
    assign bus_nb.raddr2 = bus.raddr2;
    assign bus_nb.clr    = bus.clr;

    mycpu_regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    mycpu_regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_nb)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic do_write(input logic [4:0] addr, input logic [3:0] wen, input logic [31:0] data);
        bus.waddr = addr;
        bus.wen   = wen;
        bus.wdata = data;
        @(posedge i_clk);
        #1;
        bus.wen = '0;
        $display("write addr=%0d wen=%b data=0x%08h", addr, wen, data);
    endtask

    task automatic test_reset();
        int edges;
        logic [4:0] addrs [4];
        addrs[0] = 5'd0; addrs[1] = 5'd1; addrs[2] = 5'd17; addrs[3] = 5'd31;
        i_rst_n = 1'b0;
        #12;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=1", bus.busy);
        end
        n_checks++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=0x%08h/0x%08h exp=0", bus.rdata1, bus.rdata2);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        edges = 0;
        while (bus.busy === 1'b1 && edges < 100) begin
            @(posedge i_clk);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 32) begin
            n_fail++; $display("FAIL reset_clear_len got=%0d exp=32", edges);
        end
        $display("reset released, busy low after %0d edges", edges);
        for (int i = 0; i < 4; i++) begin
            bus.raddr1 = addrs[i];
            bus.raddr2 = 5'd31 - addrs[i];
            #1;
            n_checks++;
            if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
                n_fail++; $display("FAIL post_reset_read a=%0d got=0x%08h/0x%08h exp=0", addrs[i], bus.rdata1, bus.rdata2);
            end
        end
    endtask

    task automatic test_byte_merge();
        do_write(5'd5, 4'b1111, 32'hDEADBEEF);
        do_write(5'd5, 4'b0101, 32'h11223344);
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd5;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'hDE22BE44 || bus.rdata2 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL byte_merge got=0x%08h/0x%08h exp=0xde22be44", bus.rdata1, bus.rdata2);
        end
        n_checks++;
        if (bus_nb.rdata1 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL byte_merge_nb got=0x%08h exp=0xde22be44", bus_nb.rdata1);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 4'b1111, 32'hAAAAAAAA);
        bus.waddr  = 5'd7;
        bus.wen    = 4'b0011;
        bus.wdata  = 32'h12345678;
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd5;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'hAAAA5678) begin
            n_fail++; $display("FAIL bypass_same_cycle got=0x%08h exp=0xaaaa5678", bus.rdata1);
        end
        n_checks++;
        if (bus_nb.rdata1 !== 32'hAAAAAAAA) begin
            n_fail++; $display("FAIL nobypass_same_cycle got=0x%08h exp=0xaaaaaaaa", bus_nb.rdata1);
        end
        n_checks++;
        if (bus.rdata2 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL bypass_other_port got=0x%08h exp=0xde22be44", bus.rdata2);
        end
        @(posedge i_clk);
        #1;
        bus.wen = '0;
        $display("write addr=7 wen=0011 data=0x12345678 (bypass cycle)");
        #1;
        n_checks++;
        if (bus_nb.rdata1 !== 32'hAAAA5678 || bus.rdata1 !== 32'hAAAA5678) begin
            n_fail++; $display("FAIL after_edge_read got=0x%08h/0x%08h exp=0xaaaa5678", bus.rdata1, bus_nb.rdata1);
        end
    endtask

    task automatic test_zero_reg();
        bus.waddr  = 5'd0;
        bus.wen    = 4'b1111;
        bus.wdata  = 32'hFFFFFFFF;
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_bypass got=0x%08h/0x%08h exp=0", bus.rdata1, bus.rdata2);
        end
        @(posedge i_clk);
        #1;
        bus.wen = '0;
        $display("write addr=0 wen=1111 data=0xffffffff");
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0 || bus_nb.rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_after got=0x%08h/0x%08h exp=0", bus.rdata1, bus_nb.rdata2);
        end
    endtask

    task automatic test_clear();
        int edges;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 4'b1111, 32'(i) * 32'h01010101);
        end
        bus.raddr1 = 5'd31;
        bus.raddr2 = 5'd1;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h1F1F1F1F || bus.rdata2 !== 32'h01010101) begin
            n_fail++; $display("FAIL fill_read got=0x%08h/0x%08h exp=0x1f1f1f1f/0x01010101", bus.rdata1, bus.rdata2);
        end
        bus.clr = 1'b1;
        @(posedge i_clk);
        #1;
        bus.clr = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL clr_start busy=%b rdata1=0x%08h exp busy=1 rdata1=0", bus.busy, bus.rdata1);
        end
        edges = 0;
        while (bus.busy === 1'b1 && edges < 100) begin
            if (edges == 2) begin
                bus.waddr = 5'd1;
                bus.wen   = 4'b1111;
                bus.wdata = 32'hCAFEF00D;
            end else begin
                bus.wen = '0;
            end
            @(posedge i_clk);
            #1;
            edges++;
        end
        bus.wen = '0;
        n_checks++;
        if (edges != 32) begin
            n_fail++; $display("FAIL clr_len got=%0d exp=32", edges);
        end
        $display("clear done after %0d edges", edges);
        for (int a = 0; a < 32; a++) begin
            bus.raddr1 = 5'(a);
            bus.raddr2 = 5'(a);
            #1;
            n_checks++;
            if (bus.rdata1 !== 32'h0 || bus_nb.rdata2 !== 32'h0) begin
                n_fail++; $display("FAIL post_clr_read a=%0d got=0x%08h/0x%08h exp=0", a, bus.rdata1, bus_nb.rdata2);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int edges;
        do_write(5'd4, 4'b1111, 32'h44444444);
        bus.clr = 1'b1;
        @(posedge i_clk);
        #1;
        bus.clr = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        bus.raddr1 = 5'd20;
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL mid_clear_rst busy=%b rdata1=0x%08h exp busy=1 rdata1=0", bus.busy, bus.rdata1);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        edges = 0;
        while (bus.busy === 1'b1 && edges < 100) begin
            bus.clr = (edges == 5);
            @(posedge i_clk);
            #1;
            edges++;
        end
        bus.clr = 1'b0;
        n_checks++;
        if (edges != 32) begin
            n_fail++; $display("FAIL mid_clear_restart_len got=%0d exp=32", edges);
        end
        n_checks++;
        if (bus_nb.busy !== 1'b0) begin
            n_fail++; $display("FAIL nb_busy_after got=%b exp=0", bus_nb.busy);
        end
        $display("restarted clear done after %0d edges", edges);
    endtask

    task automatic test_back_to_back();
        do_write(5'd3, 4'b1111, 32'h01234567);
        do_write(5'd4, 4'b1000, 32'hAB000000);
        do_write(5'd3, 4'b0010, 32'h0000FF00);
        bus.raddr1 = 5'd3;
        bus.raddr2 = 5'd4;
        #1;
        n_checks++;
        if (bus.rdata1 !== 32'h0123FF67 || bus.rdata2 !== 32'hAB000000) begin
            n_fail++; $display("FAIL back_to_back got=0x%08h/0x%08h exp=0x0123ff67/0xab000000", bus.rdata1, bus.rdata2);
        end
        bus.waddr = 5'd4;
        bus.wen   = 4'b0001;
        bus.wdata = 32'h000000CD;
        #1;
        n_checks++;
        if (bus.rdata2 !== 32'hAB0000CD || bus.rdata1 !== 32'h0123FF67 || bus_nb.rdata2 !== 32'hAB000000) begin
            n_fail++; $display("FAIL bypass_port2 got=0x%08h/0x%08h nb=0x%08h exp=0xab0000cd/0x0123ff67 nb=0xab000000",
                               bus.rdata2, bus.rdata1, bus_nb.rdata2);
        end
        @(posedge i_clk);
        #1;
        bus.wen = '0;
        $display("write addr=4 wen=0001 data=0x000000cd (bypass cycle)");
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        i_rst_n    = 1'b0;
        bus.wen    = '0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        bus.clr    = 1'b0;
        test_reset();
        test_byte_merge();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
